reset_pulse_gen: RTL and testbench

//   Initiator side of the design's reset fabric: generates a timed, active-low reset

---
 rtl/reset_pulse_gen.sv | 173 +++++++++++++++++
 tb/tb_reset_pulse_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_pulse_gen.sv
//============================================================================
// Module      : reset_pulse_gen
// Description : Initiator side of the reset fabric. Drives a timed active-low
//               reset pulse into a downstream reset synchronizer and completes
//               a handshake by watching that synchronizer's released resetn.
//               Optional ack-wait timeout enabled by RESET_PULSE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module reset_pulse_gen #(
  parameter int PULSE_CYCLES   = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ack_resetn,
  output logic resetn_out,
  output logic reset_out,
  output logic busy,
  output logic done,
  output logic timeout
);

  localparam int                 c_CNT_W    = $clog2(PULSE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2,
    ST_IDLE    = 2'd3
  } state_t;

  // Elaboration-time guards on parameter ranges
  if (PULSE_CYCLES < 1) begin : g_chk_pulse
    $error("PULSE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_resetn_out;
  logic                 r_busy;
  logic                 r_done;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                 w_ack_s;
  logic                 w_wait_hit;

`ifdef RESET_PULSE_TIMEOUT_EN
  localparam int                  c_WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [c_WAIT_W-1:0] r_wait;
  logic                r_timeout;

  // The wait limit is reached on the last allowed waiting cycle
  assign w_wait_hit = (r_wait == c_WAIT_LAST);
  assign timeout    = r_timeout;
`else
  // Waits are unbounded in this build
  assign w_wait_hit = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Bring the downstream released-resetn into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_resetn};
    end
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // Pulse sequencer: hold low for the minimum time, then handshake with downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ASSERT;
      r_cnt        <= '0;
      r_resetn_out <= 1'b0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
`ifdef RESET_PULSE_TIMEOUT_EN
      r_wait       <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_ASSERT: begin
          r_resetn_out <= 1'b0;
          if (r_cnt != c_CNT_LAST) begin
            // Still inside the minimum low phase; the ack wait starts fresh
            r_cnt <= r_cnt + 1'b1;
`ifdef RESET_PULSE_TIMEOUT_EN
            r_wait <= '0;
`endif
          end else if (!w_ack_s || w_wait_hit) begin
            // Downstream has seen reset (or we gave up waiting): release it
            r_state      <= ST_RELEASE;
            r_resetn_out <= 1'b1;
`ifdef RESET_PULSE_TIMEOUT_EN
            r_wait <= '0;
            if (w_ack_s) begin
              r_timeout <= 1'b1;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
`endif
          end
        end

        ST_RELEASE: begin
          r_resetn_out <= 1'b1;
          if (w_ack_s || w_wait_hit) begin
            // First cycle with ack seen high completes the sequence
            r_state <= ST_DONE;
            r_done  <= 1'b1;
`ifdef RESET_PULSE_TIMEOUT_EN
            if (!w_ack_s) begin
              r_timeout <= 1'b1;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
`endif
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        ST_IDLE: begin
          r_resetn_out <= 1'b1;
          if (req) begin
            // Accept a request: resetn_out falls on this same edge
            r_state      <= ST_ASSERT;
            r_cnt        <= '0;
            r_resetn_out <= 1'b0;
            r_busy       <= 1'b1;
`ifdef RESET_PULSE_TIMEOUT_EN
            r_wait    <= '0;
            r_timeout <= 1'b0;
`endif
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign resetn_out = r_resetn_out;
  assign reset_out  = ~r_resetn_out;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_reset_pulse_gen.sv
//============================================================================
// Module      : tb_reset_pulse_gen
// Description : Self-checking bench for reset_pulse_gen. A downstream model
//               echoes resetn_out back on ack_resetn with a 2-cycle lag (or
//               holds it stuck). Expected per-sequence results are queued when
//               stimulus is driven and checked when done is observed.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_reset_pulse_gen;

  localparam int PULSE_CYCLES   = 16;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic req   = 1'b0;
  logic ack_resetn;
  logic resetn_out, reset_out, busy, done, timeout;

  always #5 clk = ~clk;

  // Downstream model: 0 = follow resetn_out with 2-cycle lag, 1 = stuck 1, 2 = stuck 0
  int   ack_mode = 0;
  logic r_d1 = 1'b1;
  logic r_d2 = 1'b1;
  always @(posedge clk) begin
    r_d1 <= resetn_out;
    r_d2 <= r_d1;
  end
  assign ack_resetn = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? 1'b0 : r_d2;

  reset_pulse_gen #(
    .PULSE_CYCLES  (PULSE_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ack_resetn(ack_resetn),
    .resetn_out(resetn_out),
    .reset_out (reset_out),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int lo_min;
    int lo_max;
    int to_exp;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int mn, input int mx, input int to);
    exp_t e;
    e.lo_min = mn;
    e.lo_max = mx;
    e.to_exp = to;
    sb.push_back(e);
  endtask

  // Monitor: measures low-phase, release and idle lengths; scores each done
  int   run_low = 0, last_low = 0;
  int   rel_len = 0, last_rel = 0;
  int   idle_len = 0, last_idle = 0;
  int   done_count = 0;
  logic prev_done = 1'b0;
  logic prev_busy = 1'b1;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        run_low   = 0;
        rel_len   = 0;
        idle_len  = 0;
        prev_done = 1'b0;
        prev_busy = 1'b1;
      end else begin
        if (!resetn_out) run_low++;
        else if (run_low != 0) begin
          last_low = run_low;
          run_low  = 0;
        end
        if (busy && resetn_out && !done) rel_len++;
        if (!busy) idle_len++;
        else if (!prev_busy) begin
          last_idle = idle_len;
          idle_len  = 0;
        end
        if (done) begin
          check_eq("done_single_cycle", {31'd0, prev_done}, 0);
          done_count++;
          last_rel = rel_len;
          rel_len  = 0;
          check_eq("sb_nonempty_on_done", {31'd0, (sb.size() > 0)}, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.lo_min == e.lo_max)
              check_eq("low_len", last_low, e.lo_min);
            else
              check_eq($sformatf("low_len_%0d_in_%0d_%0d", last_low, e.lo_min, e.lo_max),
                       {31'd0, (last_low >= e.lo_min && last_low <= e.lo_max)}, 1);
            check_eq("timeout_at_done", {31'd0, timeout}, e.to_exp);
            check_eq("busy_at_done", {31'd0, busy}, 1);
          end
        end
        prev_done = done;
        prev_busy = busy;
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_count < target; i++) @(posedge clk);
    check_eq($sformatf("done_%0d_within_budget", target), {31'd0, (done_count >= target)}, 1);
  endtask

  task automatic wait_release(input int budget);
    for (int i = 0; i < budget && !(busy && resetn_out && !done); i++) @(negedge clk);
    check_eq("release_reached", {31'd0, (busy && resetn_out && !done)}, 1);
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: power-up sequence
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_resetn_out", {31'd0, resetn_out}, 0);
    check_eq("rst_reset_out",  {31'd0, reset_out}, 1);
    check_eq("rst_busy",       {31'd0, busy}, 1);
    check_eq("rst_done",       {31'd0, done}, 0);
    check_eq("rst_timeout",    {31'd0, timeout}, 0);
    push_exp(16, 16, 0);
    reset = 1'b0;
    wait_done(1, 200);
    @(negedge clk);
    check_eq("idle_busy_after_powerup", {31'd0, busy}, 0);

    // 2: single request, first-edge response
    @(posedge clk); #1 req = 1'b1;
    check_eq("idle_resetn_before_req", {31'd0, resetn_out}, 1);
    push_exp(16, 16, 0);
    @(posedge clk); #1 req = 1'b0;
    check_eq("resetn_falls_next_edge", {31'd0, resetn_out}, 0);
    check_eq("busy_after_req", {31'd0, busy}, 1);
    wait_done(2, 200);

    // 3: downstream slow to report reset: ack held high ~40 cycles
    @(posedge clk); #1 req = 1'b1;
    ack_mode = 1;
`ifdef RESET_PULSE_TIMEOUT_EN
    push_exp(22, 25, 1);
`else
    push_exp(41, 45, 0);
`endif
    @(posedge clk); #1 req = 1'b0;
    repeat (39) @(posedge clk);
    #1 ack_mode = 0;
    wait_done(3, 200);
`ifdef RESET_PULSE_TIMEOUT_EN
    repeat (5) @(negedge clk);
    check_eq("timeout_sticky_assert", {31'd0, timeout}, 1);
`endif

    // 4: requests during ASSERT and RELEASE are ignored
    @(posedge clk); #1 req = 1'b1;
    push_exp(16, 16, 0);
    @(posedge clk); #1 req = 1'b0;
    repeat (5) @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    wait_release(100);
    #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    wait_done(4, 200);
    repeat (30) @(posedge clk);
    #1;
    check_eq("one_done_for_ignored_reqs", done_count, 4);
    check_eq("idle_after_ignored_reqs", {31'd0, busy}, 0);

    // 4b: req held high gives back-to-back sequences, one IDLE cycle apart
    @(posedge clk); #1 req = 1'b1;
    push_exp(16, 16, 0);
    push_exp(16, 16, 0);
    wait_done(5, 200);
    @(negedge clk);
    @(negedge clk);
    #1 req = 1'b0;
    check_eq("busy_again_after_idle", {31'd0, busy}, 1);
    check_eq("idle_gap_cycles", last_idle, 1);
    wait_done(6, 200);

    // 5: reset mid-RELEASE aborts and re-runs a full pulse
    pulse_req();
    push_exp(16, 16, 0);
    wait_release(100);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    check_eq("midrst_resetn_out", {31'd0, resetn_out}, 0);
    check_eq("midrst_busy",       {31'd0, busy}, 1);
    check_eq("midrst_done",       {31'd0, done}, 0);
    @(posedge clk); #1 reset = 1'b0;
    push_exp(16, 16, 0);
    wait_done(7, 200);

    // 6: ack stuck low during RELEASE
    @(posedge clk); #1 req = 1'b1;
    ack_mode = 2;
`ifdef RESET_PULSE_TIMEOUT_EN
    push_exp(16, 16, 1);
    @(posedge clk); #1 req = 1'b0;
    wait_done(8, 200);
    check_eq("release_len_timeout", last_rel, 8);
    repeat (3) @(negedge clk);
    check_eq("timeout_sticky_release", {31'd0, timeout}, 1);
    ack_mode = 0;
    @(posedge clk); #1 req = 1'b1;
    push_exp(16, 16, 0);
    @(posedge clk); #1 req = 1'b0;
    check_eq("timeout_cleared_on_req", {31'd0, timeout}, 0);
    wait_done(9, 200);
`else
    push_exp(16, 16, 0);
    @(posedge clk); #1 req = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check_eq("no_done_while_stuck", done_count, 7);
    check_eq("no_timeout_build",    {31'd0, timeout}, 0);
    check_eq("still_busy_stuck",    {31'd0, busy}, 1);
    check_eq("released_while_stuck", {31'd0, resetn_out}, 1);
    ack_mode = 0;
    wait_done(8, 200);
`endif

    repeat (5) @(posedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
